// File: rtl/ed25519_io_ctrl.sv
// ed25519_io_ctrl: stream deserialiser/serialiser around the ed25519 scalar-mult core
module ed25519_io_ctrl #(
  parameter int DATA_W = 64,
  parameter int PATN_W = 256
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_core_start,
  output logic [PATN_W-1:0] o_scalar,
  output logic [PATN_W-1:0] o_px,
  output logic [PATN_W-1:0] o_py,
  input  logic              i_core_done,
  input  logic [PATN_W-1:0] i_qx,
  input  logic [PATN_W-1:0] i_qy
);
  localparam int IN_WORDS = 3*PATN_W/DATA_W;
  localparam int OUT_WORDS = 2*PATN_W/DATA_W;
  localparam int CNT_W = $clog2(IN_WORDS);
  localparam logic [CNT_W-1:0] LAST_IN = CNT_W'(IN_WORDS-1);
  localparam logic [CNT_W-1:0] LAST_OUT = CNT_W'(OUT_WORDS-1);
  typedef enum logic [1:0] {S_IN, S_CALC, S_OUT} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [3*PATN_W-1:0] in_sr;
  logic [2*PATN_W-1:0] out_sr;
  assign o_scalar = in_sr[3*PATN_W-1 -: PATN_W];
  assign o_px = in_sr[2*PATN_W-1 -: PATN_W];
  assign o_py = in_sr[PATN_W-1:0];
  assign o_out_data = out_sr[2*PATN_W-1 -: DATA_W];
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IN;
      cnt <= '0;
      in_sr <= '0;
      out_sr <= '0;
      o_in_ready <= 1'b0;
      o_out_valid <= 1'b0;
      o_core_start <= 1'b0;
    end else begin
      o_core_start <= 1'b0;
      case (state)
        S_IN:
          if (o_in_ready && i_in_valid) begin
            in_sr <= {in_sr[3*PATN_W-DATA_W-1:0], i_in_data};
            cnt <= (cnt == LAST_IN) ? '0 : cnt + 1'b1;
            if (cnt == LAST_IN) begin
              o_in_ready <= 1'b0;
              o_core_start <= 1'b1;
              state <= S_CALC;
            end
          end else begin
            o_in_ready <= 1'b1;
          end
        S_CALC:
          if (i_core_done) begin
            out_sr <= {i_qx, i_qy};
            o_out_valid <= 1'b1;
            state <= S_OUT;
          end
        S_OUT:
          if (i_out_ready) begin
            out_sr <= out_sr << DATA_W;
            cnt <= (cnt == LAST_OUT) ? '0 : cnt + 1'b1;
            if (cnt == LAST_OUT) begin
              o_out_valid <= 1'b0;
              o_in_ready <= 1'b1;
              state <= S_IN;
            end
          end
        default: state <= S_IN;
      endcase
    end
  end
endmodule

// File: tb/tb_ed25519_io_ctrl.sv
// tb_ed25519_io_ctrl: table-driven jobs with an output-word scoreboard
module tb_ed25519_io_ctrl;
  localparam int DW = 64;
  localparam int PW = 256;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, core_start, core_done = 1'b0;
  logic [DW-1:0] in_data = '0, out_data;
  logic [PW-1:0] scalar, px, py, qx = '0, qy = '0;
  int errs = 0, checks = 0;
  logic [DW-1:0] exp_q[$];
  typedef struct {
    logic [DW-1:0] base;
    logic [PW-1:0] qx;
    logic [PW-1:0] qy;
    int in_gap;
    int out_stall;
    bit glitch;
  } job_t;
  job_t jobs[3];
  ed25519_io_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_core_start(core_start), .o_scalar(scalar), .o_px(px), .o_py(py),
    .i_core_done(core_done), .i_qx(qx), .i_qy(qy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [PW-1:0] rnd256();
    logic [PW-1:0] r;
    for (int k = 0; k < 8; k++) r = {r[PW-33:0], 32'($urandom)};
    return r;
  endfunction
  task automatic feed(input logic [DW-1:0] base, input int gap, input int n);
    int i = 0, cyc = 0;
    while (i < n && cyc < 1000) begin
      @(negedge clk);
      in_valid = ($urandom_range(99) >= gap);
      in_data = base + DW'(i + 1);
      if (in_valid && in_ready) i++;
      cyc++;
    end
    if (i < n) chk("feed_timeout", PW'(i), PW'(n));
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic drain(input int stall, input bit glitch, input int nmax);
    int cyc = 0, n = 0;
    logic [DW-1:0] prev = '0;
    bit was_stall = 0;
    while (n < nmax && cyc < 500) begin
      chk("out_valid_in_S_OUT", PW'(out_valid), PW'(1));
      if (was_stall) chk("stall_hold", PW'(out_data), PW'(prev));
      out_ready = ($urandom_range(99) >= stall);
      core_done = glitch && cyc == 2;
      qx = ~'0;
      qy = ~'0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("scoreboard_empty", PW'(0), PW'(1));
        else chk("out_word", PW'(out_data), PW'(exp_q.pop_front()));
        n++;
        was_stall = 0;
      end else begin
        was_stall = out_valid;
        prev = out_data;
      end
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    core_done = 1'b0;
    if (n < nmax) chk("drain_timeout", PW'(n), PW'(nmax));
    if (stall == 0 && nmax == 8) chk("consecutive_cycles", PW'(cyc), PW'(8));
  endtask
  task automatic run_job(input job_t j, input int nout);
    logic [3*PW-1:0] exp_ops = '0;
    for (int k = 0; k < 12; k++) exp_ops = {exp_ops[3*PW-DW-1:0], j.base + DW'(k + 1)};
    feed(j.base, j.in_gap, 12);
    chk("core_start_pulse", PW'(core_start), PW'(1));
    chk("in_ready_low_calc", PW'(in_ready), PW'(0));
    chk("scalar", scalar, exp_ops[3*PW-1 -: PW]);
    chk("px", px, exp_ops[2*PW-1 -: PW]);
    chk("py", py, exp_ops[PW-1:0]);
    in_valid = 1'b1;
    in_data = 64'hdead_beef_dead_beef;
    @(negedge clk);
    chk("core_start_single", PW'(core_start), PW'(0));
    @(negedge clk);
    in_valid = 1'b0;
    chk("out_valid_calc", PW'(out_valid), PW'(0));
    chk("py_hold_calc", py, exp_ops[PW-1:0]);
    core_done = 1'b1;
    qx = j.qx;
    qy = j.qy;
    for (int k = 0; k < 4; k++) exp_q.push_back(j.qx[PW-1-64*k -: DW]);
    for (int k = 0; k < 4; k++) exp_q.push_back(j.qy[PW-1-64*k -: DW]);
    @(negedge clk);
    core_done = 1'b0;
    qx = rnd256();
    qy = rnd256();
    chk("done_to_valid", PW'(out_valid), PW'(1));
    chk("first_word", PW'(out_data), PW'(j.qx[PW-1 -: DW]));
    drain(j.out_stall, j.glitch, nout);
    if (nout == 8) begin
      chk("in_ready_after_out", PW'(in_ready), PW'(1));
      chk("out_valid_after_out", PW'(out_valid), PW'(0));
      chk("scoreboard_drained", PW'(exp_q.size()), PW'(0));
    end
  endtask
  initial begin
    jobs[0] = '{64'h0, {4{64'h1111111111111111}}, {4{64'h2222222222222222}}, 0, 0, 1'b1};
    jobs[1] = '{64'h0, {4{64'h1111111111111111}}, {4{64'h2222222222222222}}, 50, 50, 1'b0};
    jobs[2] = '{64'h1000, rnd256(), rnd256(), 30, 30, 1'b1};
    repeat (3) @(negedge clk);
    chk("rst_in_ready", PW'(in_ready), PW'(0));
    chk("rst_out_valid", PW'(out_valid), PW'(0));
    chk("rst_out_data", PW'(out_data), PW'(0));
    chk("rst_core_start", PW'(core_start), PW'(0));
    chk("rst_scalar", scalar, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", PW'(in_ready), PW'(1));
    core_done = 1'b1;
    qx = rnd256();
    qy = rnd256();
    @(negedge clk);
    core_done = 1'b0;
    @(negedge clk);
    chk("done_in_S_IN_valid", PW'(out_valid), PW'(0));
    chk("done_in_S_IN_ready", PW'(in_ready), PW'(1));
    for (int t = 0; t < 3; t++) run_job(jobs[t], 8);
    feed(64'h5000, 0, 5);
    #2 rst = 1'b1;
    #1;
    chk("midin_rst_ready", PW'(in_ready), PW'(0));
    chk("midin_rst_scalar", scalar, '0);
    chk("midin_rst_py", py, '0);
    @(negedge clk);
    rst = 1'b0;
    run_job(jobs[2], 8);
    run_job(jobs[1], 3);
    #2 rst = 1'b1;
    #1;
    chk("midout_rst_valid", PW'(out_valid), PW'(0));
    chk("midout_rst_data", PW'(out_data), PW'(0));
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    run_job(jobs[0], 8);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
